// File: rtl/fbs_stack.sv
// fbs_stack: LIFO frame stack with push/pop/swap, registered read-out and sticky error flags.
// Storage is not reset; only the pointer, output register and flags are.
module fbs_stack #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              backup,
  input  logic              restore,
  input  logic              clear_err,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop, wr_en;
  logic [AW-1:0]     top_idx, wr_idx;
  assign full    = count_q == MAX_CNT;
  assign empty   = count_q == '0;
  assign top_idx = AW'(count_q - CNT_W'(1));
  always_comb begin
    push       = backup & ~restore & ~full;
    pop        = restore & ~backup & ~empty;
    wr_en      = backup & (restore ? ~empty : ~full);
    wr_idx     = restore ? top_idx : AW'(count_q);
    count_d    = push ? count_q + CNT_W'(1) : pop ? count_q - CNT_W'(1) : count_q;
    // Simultaneous request on an empty stack bypasses data_in straight to the output.
    valid_d    = restore & (backup | ~empty);
    data_out_d = ~valid_d ? data_out_q : empty ? data_in : mem_q[top_idx];
    ovf_d      = (backup & ~restore & full) | (ovf_q & ~clear_err);
    unf_d      = (restore & ~backup & empty) | (unf_q & ~clear_err);
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
endmodule

// File: tb/tb_fbs_stack.sv
// tb_fbs_stack: checks a default-size and a small (16b x 4) stack against a queue-based model.
module tb_fbs_stack;
  logic clk = 1'b0, rst_n = 1'b0, backup = 1'b0, restore = 1'b0, clear_err = 1'b0;
  logic [255:0] din = '0;
  logic [255:0] dout_a;
  logic [4:0]   cnt_a;
  logic         val_a, full_a, empty_a, ovf_a, unf_a;
  logic [15:0]  dout_b;
  logic [2:0]   cnt_b;
  logic         val_b, full_b, empty_b, ovf_b, unf_b;
  int vec = 0, errs = 0;
  logic [255:0] qa[$], qb[$];
  logic [255:0] e_dout[2];
  logic         e_val[2], e_ovf[2], e_unf[2];

  always #5 clk = ~clk;

  fbs_stack dut_a (
    .clk(clk), .rst_n(rst_n), .backup(backup), .restore(restore), .clear_err(clear_err),
    .data_in(din), .data_out(dout_a), .data_valid(val_a), .count(cnt_a),
    .full(full_a), .empty(empty_a), .overflow(ovf_a), .underflow(unf_a));

  fbs_stack #(.DATA_W(16), .DEPTH(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .backup(backup), .restore(restore), .clear_err(clear_err),
    .data_in(din[15:0]), .data_out(dout_b), .data_valid(val_b), .count(cnt_b),
    .full(full_b), .empty(empty_b), .overflow(ovf_b), .underflow(unf_b));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [255:0] q[$];
      logic [255:0] d;
      int dep, n;
      logic os, us;
      q   = k ? qb : qa;
      dep = k ? 4 : 16;
      d   = k ? {240'b0, din[15:0]} : din;
      n   = q.size();
      os  = 1'b0;
      us  = 1'b0;
      e_val[k] = 1'b0;
      if (backup && restore) begin
        e_val[k] = 1'b1;
        if (n == 0) e_dout[k] = d;
        else begin
          e_dout[k] = q[n-1];
          q[n-1] = d;
        end
      end else if (backup) begin
        if (n == dep) os = 1'b1;
        else q.push_back(d);
      end else if (restore) begin
        if (n == 0) us = 1'b1;
        else begin
          e_dout[k] = q.pop_back();
          e_val[k] = 1'b1;
        end
      end
      e_ovf[k] = os | (e_ovf[k] & ~clear_err);
      e_unf[k] = us | (e_unf[k] & ~clear_err);
      if (k == 0) qa = q;
      else qb = q;
    end
  endtask

  task automatic check_all();
    chk("a.count", cnt_a, 256'(qa.size()));
    chk("a.data_out", dout_a, e_dout[0]);
    chk("a.data_valid", val_a, e_val[0]);
    chk("a.full", full_a, qa.size() == 16);
    chk("a.empty", empty_a, qa.size() == 0);
    chk("a.overflow", ovf_a, e_ovf[0]);
    chk("a.underflow", unf_a, e_unf[0]);
    chk("b.count", cnt_b, 256'(qb.size()));
    chk("b.data_out", dout_b, e_dout[1]);
    chk("b.data_valid", val_b, e_val[1]);
    chk("b.full", full_b, qb.size() == 4);
    chk("b.empty", empty_b, qb.size() == 0);
    chk("b.overflow", ovf_b, e_ovf[1]);
    chk("b.underflow", unf_b, e_unf[1]);
  endtask

  task automatic cyc(input logic b, input logic r, input logic c, input logic [255:0] d);
    backup = b; restore = r; clear_err = c; din = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asserts reset between edges and checks the outputs respond without a clock.
  task automatic do_reset();
    backup = 1'b0; restore = 1'b0; clear_err = 1'b0;
    rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    for (int k = 0; k < 2; k++) begin
      e_dout[k] = '0; e_val[k] = 1'b0; e_ovf[k] = 1'b0; e_unf[k] = 1'b0;
    end
    chk("rst.a.count", cnt_a, 0);
    chk("rst.a.data_out", dout_a, 0);
    chk("rst.a.empty", empty_a, 1);
    chk("rst.b.count", cnt_b, 0);
    chk("rst.b.data_out", dout_b, 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic b, r, c;
    logic [255:0] d;
    int cnt;
    logic [255:0] dout;
    logic v, o, u;
  } vec_t;
  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1, 0, 0, 'hA, 1, 0,   0, 0, 0};
    tbl[1]  = '{1, 0, 0, 'hB, 2, 0,   0, 0, 0};
    tbl[2]  = '{1, 0, 0, 'hC, 3, 0,   0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0,   2, 'hC, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0,   1, 'hB, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0,   0, 'hA, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 0,   0, 'hA, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 0,   0, 'hA, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0,   0, 'hA, 0, 0, 1};
    tbl[9]  = '{0, 0, 1, 0,   0, 'hA, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 'h3, 1, 'hA, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 'h5, 2, 'hA, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 'h9, 2, 'h5, 1, 0, 0};
    tbl[13] = '{0, 1, 0, 0,   1, 'h9, 1, 0, 0};
    tbl[14] = '{0, 1, 0, 0,   0, 'h3, 1, 0, 0};
    tbl[15] = '{1, 1, 0, 'h7, 0, 'h7, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0,   0, 'h7, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].b, tbl[i].r, tbl[i].c, tbl[i].d);
      chk($sformatf("t%0d.count", i), cnt_a, 256'(tbl[i].cnt));
      chk($sformatf("t%0d.data_out", i), dout_a, tbl[i].dout);
      chk($sformatf("t%0d.data_valid", i), val_a, tbl[i].v);
      chk($sformatf("t%0d.overflow", i), ovf_a, tbl[i].o);
      chk($sformatf("t%0d.underflow", i), unf_a, tbl[i].u);
    end

    // Fill past capacity, then pop and swap at full.
    do_reset();
    for (int i = 1; i <= 17; i++) cyc(1, 0, 0, 256'(i));
    chk("ovf.a.count", cnt_a, 16);
    chk("ovf.a.full", full_a, 1);
    chk("ovf.a.overflow", ovf_a, 1);
    chk("ovf.b.count", cnt_b, 4);
    chk("ovf.b.overflow", ovf_b, 1);
    cyc(0, 1, 0, 0);
    chk("ovf.a.pop", dout_a, 'h10);
    chk("ovf.b.pop", dout_b, 'h4);
    cyc(1, 0, 1, 'h20);
    chk("ovf.a.cleared", ovf_a, 0);
    cyc(1, 1, 0, 'h99);
    chk("swapfull.a.data_out", dout_a, 'h20);
    chk("swapfull.a.count", cnt_a, 16);
    chk("swapfull.a.overflow", ovf_a, 0);
    chk("swapfull.b.data_out", dout_b, 'h20);
    chk("swapfull.b.overflow", ovf_b, 0);
    cyc(0, 1, 0, 0);
    chk("swapfull.a.next", dout_a, 'h99);

    // Reset mid-operation, then restore must underflow.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 256'(i + 'h40));
    chk("mid.a.count", cnt_a, 4);
    do_reset();
    cyc(0, 1, 0, 0);
    chk("mid.a.underflow", unf_a, 1);
    chk("mid.b.underflow", unf_b, 1);
    chk("mid.a.data_valid", val_a, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [255:0] d;
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/fbs_stack.md
FBS_STACK -- requirements
Module: fbs_stack

Interface
REQ-001 The block SHALL have parameter DATA_W, default 256, giving the frame width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of frames the stack holds; legal range 2..256.
REQ-003 The block SHALL have parameter CNT_W, default 5, giving the width of the occupancy count; it must be at least ceil(log2(DEPTH+1)).
REQ-004 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 Port backup  input  1  SHALL be the push request, sampled at clk rise.
REQ-007 Port restore  input  1  SHALL be the pop request, sampled at clk rise.
REQ-008 Port clear_err  input  1  SHALL clear the sticky error flags, sampled at clk rise.
REQ-009 Port data_in  input  DATA_W  SHALL carry the frame to be saved.
REQ-010 Port data_out  output  DATA_W  SHALL carry the last restored frame (registered).
REQ-011 Port data_valid  output  1  SHALL be a one-cycle pulse marking a new data_out value.
REQ-012 Port count  output  CNT_W  SHALL give the number of frames stored (0..DEPTH).
REQ-013 Ports full and empty  output  1 each  SHALL decode count==DEPTH and count==0 combinationally.
REQ-014 Ports overflow and underflow  output  1 each  SHALL be sticky error flags.

Function
REQ-015 Backup alone, not full: SHALL write data_in to slot[count] and increment count by 1 at that edge.
REQ-016 Backup alone, full: SHALL leave storage and count unchanged and set overflow.
REQ-017 Restore alone, not empty: SHALL load data_out with slot[count-1], decrement count, and pulse data_valid high for exactly the following cycle (latency 1 edge).
REQ-018 Restore alone, empty: SHALL leave count and data_out unchanged, keep data_valid low, and set underflow.
REQ-019 Backup and restore together, not empty: SHALL load data_out with slot[count-1], overwrite slot[count-1] with data_in in the same edge, keep count unchanged, and pulse data_valid.
REQ-020 Backup and restore together, empty: SHALL bypass data_in to data_out, pulse data_valid, keep count 0, and flag no error.
REQ-021 Backup and restore together, full: SHALL follow REQ-019 (swap); overflow SHALL NOT be set.
REQ-022 data_out SHALL hold its value between restores; data_valid SHALL be low in every cycle with no successful restore.
REQ-023 clear_err SHALL clear both sticky flags at the edge; if a new error occurs at the same edge, the set SHALL win.
REQ-024 count SHALL never wrap: it saturates at 0 and DEPTH per REQ-016/REQ-018.
REQ-025 Storage SHALL be a DEPTH x DATA_W register array with one write port and one read port indexed by count-1.

Reset
REQ-026 rst_n low SHALL immediately force count=0, data_out=0, data_valid=0, overflow=0, underflow=0; full=0, empty=1 follow.
REQ-027 Storage contents SHALL NOT be reset; they are unobservable until rewritten.
REQ-028 Reset asserted mid-operation SHALL abandon any in-flight request; the first request accepted is the one sampled at the first rising edge with rst_n high.

Verification
REQ-029 Reset, then 3 backups of 0xA, 0xB, 0xC -> count=3, empty=0; 3 restores -> data_out 0xC, 0xB, 0xA, each with a one-cycle data_valid; then count=0, empty=1.
REQ-030 DEPTH=16: 17 backups -> count=16, full=1, overflow=1 after the 17th; a restore returns the 16th frame, not the 17th.
REQ-031 Restore when empty -> underflow=1, data_valid=0, data_out unchanged; clear_err -> underflow=0; clear_err together with another empty restore -> underflow stays 1.
REQ-032 count=2 holding top 0x5, backup+restore with data_in 0x9 -> data_out=0x5, count=2; the next restore returns 0x9. With count=0, backup+restore with data_in 0x7 -> data_out=0x7, count=0, no flags.
REQ-033 Assert rst_n low between edges after 4 backups -> all outputs reset at once without waiting for clk; a subsequent restore -> underflow=1.
REQ-034 Rerun REQ-029 and REQ-030 with DATA_W=16, DEPTH=4, CNT_W=3 -> identical behaviour scaled to those widths.
